// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for ALU result/op-code pairs.
// Holds DEPTH entries of {op, y}, exposes the head combinationally, and keeps
// a saturating count of cycles in which a producer was refused.
// Optional zero/negative head flags are built only when ALU_RESULT_FLAGS_EN
// is defined; otherwise out_zero and out_neg are constant 0.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_y,
  input  logic [2:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_y,
  output logic [2:0]    out_op,
  output logic          out_zero,
  output logic          out_neg,
  output logic [CW-1:0] count,
  output logic [7:0]    stall_cnt
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Each entry is {op, y}; no reset on the array, stale data is never visible.
  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [34:0]   head;

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Write accepted entries at the tail; reset cycles discard the push.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {in_op, in_y};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap from DEPTH-1 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Count refused push attempts, holding at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Head presentation, forced to zero while the FIFO is empty.
  always_comb begin
    out_y  = '0;
    out_op = '0;
    if (out_valid) begin
      out_y  = head[31:0];
      out_op = head[34:32];
    end
  end

`ifdef ALU_RESULT_FLAGS_EN
  // Head status flags, qualified by out_valid.
  always_comb begin
    out_zero = out_valid && (out_y == '0);
    out_neg  = out_valid && out_y[31];
  end
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed stimulus with a scoreboard monitor.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ALU_RESULT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_y;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic [2:0]    out_op;
  logic          out_zero;
  logic          out_neg;
  logic [CW-1:0] count;
  logic [7:0]    stall_cnt;

  alu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .count(count), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {op, y} in acceptance order, plus model occupancy.
  logic [34:0] sb[$];
  int          mcount = 0;
  int          mstall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT against the model, then advance the model
  // to what the coming rising edge should do.
  initial begin
    logic [34:0] exp_e;
    bit          acc;
    bit          pp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("count", 32'(count), 32'(mcount));
      chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
      pp = 1'b0;
      if (mcount == 0) begin
        chk("empty out_y", out_y, 32'd0);
        chk("empty out_op", 32'(out_op), 32'd0);
        chk("empty out_zero", 32'(out_zero), 32'd0);
        chk("empty out_neg", 32'(out_neg), 32'd0);
      end else if (sb.size() == 0) begin
        chk("scoreboard underrun", 32'(sb.size()), 32'(mcount));
      end else begin
        exp_e = sb[0];
        chk("head out_y", out_y, exp_e[31:0]);
        chk("head out_op", 32'(out_op), 32'(exp_e[34:32]));
        chk("head out_zero", 32'(out_zero), 32'(FLAGS && (exp_e[31:0] == 32'd0)));
        chk("head out_neg", 32'(out_neg), 32'(FLAGS && exp_e[31]));
        if (out_ready) begin
          pp = 1'b1;
          void'(sb.pop_front());
        end
      end
      acc = in_valid && (mcount != DEPTH);
      if (acc) sb.push_back({in_op, in_y});
      if (in_valid && (mcount == DEPTH) && (mstall < 255)) mstall++;
      mcount = mcount + int'(acc) - int'(pp);
      if (rst) begin
        sb.delete();
        mcount = 0;
        mstall = 0;
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [31:0] y, input logic [2:0] op,
                     input bit ordy);
    rst = r; in_valid = v; in_y = y; in_op = op; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_y = '0; in_op = '0; out_ready = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset count", 32'(count), 32'd0);

    // Zero result, not consumed
    cyc(0, 1, 32'd0, 3'b000, 0);
    chk("zero out_valid", 32'(out_valid), 32'd1);
    chk("zero out_y", out_y, 32'd0);
    chk("zero out_zero", 32'(out_zero), 32'(FLAGS));
    chk("zero count", 32'(count), 32'd1);
    cyc(1, 0, 0, 0, 0);

    // -1 then 5, popped in order
    cyc(0, 1, 32'hFFFF_FFFF, 3'b001, 0);
    cyc(0, 1, 32'd5, 3'b010, 0);
    chk("neg count2", 32'(count), 32'd2);
    chk("neg out_y", out_y, 32'hFFFF_FFFF);
    chk("neg out_neg", 32'(out_neg), 32'(FLAGS));
    cyc(0, 0, 0, 0, 1);
    chk("neg count1", 32'(count), 32'd1);
    chk("pos out_y", out_y, 32'd5);
    chk("pos out_op", 32'(out_op), 32'd2);
    chk("pos out_neg", 32'(out_neg), 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("neg count0", 32'(count), 32'd0);

    // Fill then stall three cycles
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'(10 + i), 3'(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'd99, 3'b111, 0);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full count", 32'(count), 32'd4);
    chk("full stall_cnt", 32'(stall_cnt), 32'd3);
    chk("full head", out_y, 32'd10);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("drain count", 32'(count), 32'd0);

    // Steady push+pop at count 2, wrapping pointers
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'd100, 3'd4, 0);
    cyc(0, 1, 32'd101, 3'd5, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 32'(i), 3'(i % 8), 1);
      chk("stream count", 32'(count), 32'd2);
    end
    chk("stream head", out_y, 32'd9);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("stream drain", 32'(count), 32'd0);

    // Reset with push and pop requested
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'(200 + i), 3'(i), 0);
    cyc(1, 1, 32'd7, 3'd7, 1);
    chk("rst count", 32'(count), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_y", out_y, 32'd0);

    // Saturation of stall counter
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h8000_0000 + 32'(i), 3'(i), 0);
    for (int i = 1; i <= 300; i++) begin
      cyc(0, 1, 32'd55, 3'd3, 0);
      if (i == 254) chk("stall 254", 32'(stall_cnt), 32'd254);
      if (i == 255) chk("stall 255", 32'(stall_cnt), 32'd255);
    end
    chk("stall sat", 32'(stall_cnt), 32'd255);

    // Bounded drain
    for (int i = 0; i < 20 && count != 0; i++) cyc(0, 0, 0, 0, 1);
    chk("final count", 32'(count), 32'd0);
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
